// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control unit for the CPU core.
// The core is never clock-gated. This block produces a clock enable, cpu_en_o, that every
// pipeline stage uses to decide whether to advance.
//
// Ports
//   clk_i, reset_n_i      system clock; synchronous active-low reset
//   btn_*_i               raw asynchronous board buttons (pause, continue, step, error, uart)
//   exc_code_i            exception code from execute stage (0 = none)
//   pc_i                  PC of the instruction about to execute
//   bp_en_i, bp_addr_i    per-channel breakpoint enable / address (channel k at k*ADDR_W)
//   set_cnt_i             clear the cycle counter
//   upg_done_i            UART programming finished (level)
//   cpu_en_o              core advances one instruction this cycle
//   mode_o                0 RUN, 1 PAUSE, 2 STEP, 3 ERROR, 4 BREAK, 6 UART
//   cycle_cnt_o           saturating executed-cycle counter
//   exc_latch_o           exception code that caused ERROR
//   bp_hit_o              breakpoint channel(s) that caused BREAK
module cpu_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int ADDR_W     = 32,
  parameter int EXC_W      = 4,
  parameter int NUM_BP     = 2,
  parameter int DEB_CYCLES = 20,
  parameter int RUN_ON_RST = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     btn_pause_i,
  input  logic                     btn_continue_i,
  input  logic                     btn_step_i,
  input  logic                     btn_err_i,
  input  logic                     btn_uart_i,
  input  logic [EXC_W-1:0]         exc_code_i,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [NUM_BP-1:0]        bp_en_i,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr_i,
  input  logic                     set_cnt_i,
  input  logic                     upg_done_i,
  output logic                     cpu_en_o,
  output logic [3:0]               mode_o,
  output logic [CNT_W-1:0]         cycle_cnt_o,
  output logic [EXC_W-1:0]         exc_latch_o,
  output logic [NUM_BP-1:0]        bp_hit_o
);

  typedef enum logic [3:0] {
    MODE_RUN   = 4'd0,
    MODE_PAUSE = 4'd1,
    MODE_STEP  = 4'd2,
    MODE_ERROR = 4'd3,
    MODE_BREAK = 4'd4,
    MODE_UART  = 4'd6
  } mode_e;

  localparam int    NBTN     = 5;
  localparam int    BTN_P    = 0;
  localparam int    BTN_C    = 1;
  localparam int    BTN_S    = 2;
  localparam int    BTN_E    = 3;
  localparam int    BTN_U    = 4;
  localparam int    DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam mode_e RST_MODE = (RUN_ON_RST != 0) ? MODE_RUN : MODE_PAUSE;

  logic [NBTN-1:0]   btn_raw_s;
  logic [NBTN-1:0]   sync1_r;
  logic [NBTN-1:0]   sync2_r;
  logic [NBTN-1:0]   stable_r;
  logic [DEB_W-1:0]  deb_cnt_r [NBTN];
  logic [NBTN-1:0]   pulse_s;

  mode_e             mode_r;
  mode_e             mode_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [EXC_W-1:0]  exc_latch_r;
  logic [NUM_BP-1:0] bp_hit_r;
  logic              skip_r;

  logic [NUM_BP-1:0] bp_vec_s;
  logic              bp_match_s;
  logic              exc_err_s;
  logic [EXC_W-1:0]  exc_val_s;
  logic              cpu_en_s;
  logic              latch_exc_s;
  logic              clr_exc_s;
  logic              set_hit_s;
  logic              uart_exit_s;
  logic              leave_hold_s;

  assign btn_raw_s = {btn_uart_i, btn_err_i, btn_step_i, btn_continue_i, btn_pause_i};

  // Button synchroniser and debounce counters.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync1_r  <= {NBTN{1'b0}};
      sync2_r  <= {NBTN{1'b0}};
      stable_r <= {NBTN{1'b0}};
      for (int i = 0; i < NBTN; i++) begin
        deb_cnt_r[i] <= {DEB_W{1'b0}};
      end
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_r[i] != stable_r[i]) begin
          // The DEB_CYCLES-th consecutive differing sample commits the new level.
          if (deb_cnt_r[i] == DEB_W'(DEB_CYCLES - 1)) begin
            stable_r[i]  <= sync2_r[i];
            deb_cnt_r[i] <= {DEB_W{1'b0}};
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_r[i] <= {DEB_W{1'b0}};
        end
      end
    end
  end

  // Press pulses: high in the cycle whose closing edge accepts a 0->1 level.
  always_comb begin
    pulse_s = {NBTN{1'b0}};
    for (int i = 0; i < NBTN; i++) begin
      pulse_s[i] = sync2_r[i] && !stable_r[i] && (deb_cnt_r[i] == DEB_W'(DEB_CYCLES - 1));
    end
  end

  // Breakpoint compare against current-cycle PC and channel settings.
  always_comb begin
    bp_vec_s = {NUM_BP{1'b0}};
    for (int k = 0; k < NUM_BP; k++) begin
      bp_vec_s[k] = bp_en_i[k] && (pc_i == bp_addr_i[k*ADDR_W +: ADDR_W]);
    end
    // skip_r lets the instruction sitting on a breakpoint execute once after resume.
    bp_match_s = (|bp_vec_s) && !skip_r;
  end

  // Mode state register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mode_r <= RST_MODE;
    end else begin
      mode_r <= mode_nxt_s;
    end
  end

  // Next mode, clock enable and side-effect strobes, in priority order.
  always_comb begin
    mode_nxt_s  = mode_r;
    latch_exc_s = 1'b0;
    clr_exc_s   = 1'b0;
    set_hit_s   = 1'b0;
    uart_exit_s = 1'b0;
    exc_err_s   = (exc_code_i != {EXC_W{1'b0}}) &&
                  ((mode_r == MODE_RUN) || (mode_r == MODE_STEP));
    exc_val_s   = exc_err_s ? exc_code_i : {EXC_W{1'b0}};
    cpu_en_s    = ((mode_r == MODE_RUN) && !bp_match_s && (exc_code_i == {EXC_W{1'b0}})) ||
                  (mode_r == MODE_STEP);

    if (pulse_s[BTN_U] && (mode_r != MODE_UART)) begin
      mode_nxt_s = MODE_UART;
    end else if (pulse_s[BTN_E] || exc_err_s) begin
      mode_nxt_s  = MODE_ERROR;
      latch_exc_s = 1'b1;
    end else if ((mode_r == MODE_RUN) && bp_match_s) begin
      mode_nxt_s = MODE_BREAK;
      set_hit_s  = 1'b1;
    end else if ((mode_r == MODE_RUN) && pulse_s[BTN_P]) begin
      mode_nxt_s = MODE_PAUSE;
    end else if (((mode_r == MODE_PAUSE) || (mode_r == MODE_BREAK)) && pulse_s[BTN_S]) begin
      mode_nxt_s = MODE_STEP;
    end else if (mode_r == MODE_STEP) begin
      mode_nxt_s = MODE_PAUSE;
    end else if (((mode_r == MODE_PAUSE) || (mode_r == MODE_BREAK)) && pulse_s[BTN_C]) begin
      mode_nxt_s = MODE_RUN;
    end else if ((mode_r == MODE_ERROR) && pulse_s[BTN_C]) begin
      mode_nxt_s = MODE_PAUSE;
      clr_exc_s  = 1'b1;
    end else if ((mode_r == MODE_UART) && upg_done_i) begin
      mode_nxt_s  = MODE_PAUSE;
      uart_exit_s = 1'b1;
    end else begin
      mode_nxt_s = mode_r;
    end

    leave_hold_s = ((mode_r == MODE_PAUSE) || (mode_r == MODE_BREAK)) &&
                   ((mode_nxt_s == MODE_RUN) || (mode_nxt_s == MODE_STEP));
  end

  // Exception latch.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      exc_latch_r <= {EXC_W{1'b0}};
    end else if (latch_exc_s) begin
      exc_latch_r <= exc_val_s;
    end else if (clr_exc_s) begin
      exc_latch_r <= {EXC_W{1'b0}};
    end else begin
      exc_latch_r <= exc_latch_r;
    end
  end

  // Breakpoint hit record, held for the whole BREAK stay.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bp_hit_r <= {NUM_BP{1'b0}};
    end else if (set_hit_s) begin
      bp_hit_r <= bp_vec_s;
    end else if ((mode_r == MODE_BREAK) && (mode_nxt_s != MODE_BREAK)) begin
      bp_hit_r <= {NUM_BP{1'b0}};
    end else begin
      bp_hit_r <= bp_hit_r;
    end
  end

  // Breakpoint skip flag: armed on resume, dropped after the first executed cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      skip_r <= 1'b0;
    end else if (leave_hold_s) begin
      skip_r <= 1'b1;
    end else if (cpu_en_s) begin
      skip_r <= 1'b0;
    end else begin
      skip_r <= skip_r;
    end
  end

  // Saturating cycle counter; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (set_cnt_i || uart_exit_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cpu_en_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cpu_en_o    = cpu_en_s;
  assign mode_o      = mode_r;
  assign cycle_cnt_o = cnt_r;
  assign exc_latch_o = exc_latch_r;
  assign bp_hit_o    = bp_hit_r;

endmodule
